// File: rtl/arb_types.sv
// rtl/arb_types.sv - shared types and default widths for the cache arbiter
package arb_types;

    localparam int ARB_LINE_W = 256;
    localparam int ARB_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10,
        DONE    = 2'b11
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// rtl/cache_arbiter_if.sv - icache/dcache/adaptor line-transfer signals
interface cache_arbiter_if
    import arb_types::*;
#(
    parameter int LINE_W = ARB_LINE_W,
    parameter int ADDR_W = ARB_ADDR_W
);

    logic              icache_pmem_read;
    logic [ADDR_W-1:0] icache_pmem_address;
    logic [LINE_W-1:0] icache_pmem_rdata;
    logic              icache_pmem_resp;

    logic              dcache_pmem_read;
    logic              dcache_pmem_write;
    logic [ADDR_W-1:0] dcache_pmem_address;
    logic [LINE_W-1:0] dcache_pmem_wdata;
    logic [LINE_W-1:0] dcache_pmem_rdata;
    logic              dcache_pmem_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    // Arbiter side: takes cache requests, drives the single adaptor port.
    modport slave (
        input  icache_pmem_read, icache_pmem_address,
        output icache_pmem_rdata, icache_pmem_resp,
        input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        output dcache_pmem_rdata, dcache_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    // Environment side: the two caches plus the cacheline adaptor.
    modport master (
        output icache_pmem_read, icache_pmem_address,
        input  icache_pmem_rdata, icache_pmem_resp,
        output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        input  dcache_pmem_rdata, dcache_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - dcache-priority arbiter with icache starvation guard
module cache_arbiter
    import arb_types::*;
#(
    parameter int LINE_W       = ARB_LINE_W,
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    cache_arbiter_if.slave  bus
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_t        state;
    arb_state_t        next_state;
    arb_op_t           lat_op;
    logic [ADDR_W-1:0] lat_addr;
    logic [LINE_W-1:0] lat_wdata;
    logic [3:0]        starve_cnt;

    logic i_pend;
    logic d_pend;
    logic granted;
    logic i_owner;
    logic d_owner;

    assign i_pend = bus.icache_pmem_read;
    assign d_pend = bus.dcache_pmem_read | bus.dcache_pmem_write;

    // Arbitration and next-state: dcache wins unless icache has been starved to the limit.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (d_pend && (!i_pend || starve_cnt != STARVE_MAX)) begin
                    next_state = GRANT_D;
                end else if (i_pend) begin
                    next_state = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (bus.pmem_resp) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register, owner's transaction latch and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_op     <= OP_READ;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            starve_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == GRANT_D) begin
                lat_addr  <= bus.dcache_pmem_address;
                lat_wdata <= bus.dcache_pmem_wdata;
                lat_op    <= bus.dcache_pmem_write ? OP_WRITE : OP_READ;
                if (i_pend && starve_cnt != STARVE_MAX) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else if (state == IDLE && next_state == GRANT_I) begin
                lat_addr   <= bus.icache_pmem_address;
                lat_wdata  <= '0;
                lat_op     <= OP_READ;
                starve_cnt <= '0;
            end
        end
    end

    // Flag the illegal dcache read+write combination; the write is still the one issued.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE) begin
            assert (!(bus.dcache_pmem_read && bus.dcache_pmem_write))
                else $warning("dcache read and write both high, write issued");
        end
    end

    assign granted = !rst && (state == GRANT_I || state == GRANT_D);
    assign i_owner = !rst && state == GRANT_I;
    assign d_owner = !rst && state == GRANT_D;

    assign bus.pmem_read    = granted && lat_op == OP_READ;
    assign bus.pmem_write   = granted && lat_op == OP_WRITE;
    assign bus.pmem_address = granted ? lat_addr : '0;
    assign bus.pmem_wdata   = granted ? lat_wdata : '0;

    assign bus.icache_pmem_resp  = i_owner && bus.pmem_resp;
    assign bus.icache_pmem_rdata = i_owner ? bus.pmem_rdata : '0;
    assign bus.dcache_pmem_resp  = d_owner && bus.pmem_resp;
    assign bus.dcache_pmem_rdata = d_owner ? bus.pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed vector and sequence bench for cache_arbiter
module tb_cache_arbiter;
    import arb_types::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    cache_arbiter_if #(.LINE_W(256), .ADDR_W(32)) bus ();

    cache_arbiter #(.LINE_W(256), .ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         ird;
        logic         drd;
        logic         dwr;
        logic [31:0]  iaddr;
        logic [31:0]  daddr;
        logic [255:0] wdata;
        logic [255:0] rdata;
        int           lat;
        logic         exp_rd;
        logic         exp_wr;
        logic [31:0]  exp_addr;
        logic [255:0] exp_wdata;
        logic         exp_i;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.icache_pmem_read    = 1'b0;
        bus.icache_pmem_address = '0;
        bus.dcache_pmem_read    = 1'b0;
        bus.dcache_pmem_write   = 1'b0;
        bus.dcache_pmem_address = '0;
        bus.dcache_pmem_wdata   = '0;
        bus.pmem_rdata          = '0;
        bus.pmem_resp           = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bus.icache_pmem_read    = v.ird;
        bus.icache_pmem_address = v.iaddr;
        bus.dcache_pmem_read    = v.drd;
        bus.dcache_pmem_write   = v.dwr;
        bus.dcache_pmem_address = v.daddr;
        bus.dcache_pmem_wdata   = v.wdata;
        #1;
        chk({tag, "_idle_quiet"}, {bus.pmem_read, bus.pmem_write}, 2'b00);
        tick();
        chk({tag, "_pmem_read"}, bus.pmem_read, v.exp_rd);
        chk({tag, "_pmem_write"}, bus.pmem_write, v.exp_wr);
        chk({tag, "_pmem_address"}, bus.pmem_address, v.exp_addr);
        chk({tag, "_pmem_wdata"}, bus.pmem_wdata, v.exp_wdata);
        repeat (v.lat) tick();
        bus.pmem_rdata = v.rdata;
        bus.pmem_resp  = 1'b1;
        #1;
        chk({tag, "_icache_resp"}, bus.icache_pmem_resp, v.exp_i);
        chk({tag, "_dcache_resp"}, bus.dcache_pmem_resp, !v.exp_i);
        chk({tag, "_owner_rdata"}, v.exp_i ? bus.icache_pmem_rdata : bus.dcache_pmem_rdata, v.rdata);
        tick();
        clear_inputs();
        #1;
        chk({tag, "_done_quiet"}, {bus.pmem_read, bus.pmem_write, bus.icache_pmem_resp}, 3'b000);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_i_order [7];
        int   dcount;

        //         ird   drd   dwr   iaddr         daddr         wdata                  rdata                  lat rd    wr    exp_addr      exp_wdata              exp_i
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h00000060, 32'h00000000, {8{32'hDEADBEEF}},     {32{8'hA5}},           5, 1'b1, 1'b0, 32'h00000060, 256'h0,                1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000080, 256'h0,                {8{32'h0F0F0F0F}},     2, 1'b1, 1'b0, 32'h00000080, 256'h0,                1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00000200, {8{32'h12345678}},     256'h0,                1, 1'b0, 1'b1, 32'h00000200, {8{32'h12345678}},     1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h00000100, 32'h00000300, 256'h0,                {8{32'h33333333}},     3, 1'b1, 1'b0, 32'h00000300, 256'h0,                1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h00000000, 32'h00000400, {8{32'hCAFEF00D}},     256'h0,                1, 1'b0, 1'b1, 32'h00000400, {8{32'hCAFEF00D}},     1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h00000140, 32'h00000000, 256'h0,                {8{32'h5A5A5A5A}},     2, 1'b1, 1'b0, 32'h00000140, 256'h0,                1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h00000180, 32'h000002A0, {8{32'h87654321}},     256'h0,                1, 1'b0, 1'b1, 32'h000002A0, {8{32'h87654321}},     1'b0};

        do_reset();
        chk("reset_outputs", {bus.pmem_read, bus.pmem_write, bus.icache_pmem_resp, bus.dcache_pmem_resp}, 4'b0000);
        chk("reset_address", bus.pmem_address, 32'h0);
        chk("reset_starve", dut.starve_cnt, 4'd0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Simultaneous icache read and dcache write: dcache first, then icache.
        do_reset();
        bus.icache_pmem_read    = 1'b1;
        bus.icache_pmem_address = 32'h00000100;
        bus.dcache_pmem_write   = 1'b1;
        bus.dcache_pmem_address = 32'h00000200;
        bus.dcache_pmem_wdata   = {8{32'h12345678}};
        tick();
        chk("both_d_write", {bus.pmem_read, bus.pmem_write}, 2'b01);
        chk("both_d_addr", bus.pmem_address, 32'h00000200);
        chk("both_d_wdata", bus.pmem_wdata, {8{32'h12345678}});
        tick();
        tick();
        bus.pmem_resp = 1'b1;
        #1;
        chk("both_d_resp", {bus.dcache_pmem_resp, bus.icache_pmem_resp}, 2'b10);
        tick();
        bus.pmem_resp         = 1'b0;
        bus.dcache_pmem_write = 1'b0;
        #1;
        chk("both_done_quiet", {bus.pmem_read, bus.pmem_write}, 2'b00);
        tick();
        tick();
        chk("both_i_read", {bus.pmem_read, bus.pmem_write}, 2'b10);
        chk("both_i_addr", bus.pmem_address, 32'h00000100);
        bus.pmem_rdata = {32{8'h3C}};
        bus.pmem_resp  = 1'b1;
        #1;
        chk("both_i_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b10);
        chk("both_i_rdata", bus.icache_pmem_rdata, {32{8'h3C}});
        tick();
        clear_inputs();
        tick();

        // Starvation guard: icache holds a read while dcache issues six reads.
        do_reset();
        exp_i_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        dcount = 0;
        bus.icache_pmem_read    = 1'b1;
        bus.icache_pmem_address = 32'h00001000;
        bus.dcache_pmem_read    = 1'b1;
        bus.dcache_pmem_address = 32'h00002000;
        for (int k = 0; k < 7; k++) begin
            if (k == 4) chk("starve_at_limit", dut.starve_cnt, 4'd4);
            tick();
            chk($sformatf("starve_order%0d", k), bus.pmem_address,
                exp_i_order[k] ? 32'h00001000 : 32'h00002000 + 32'(dcount) * 32'h20);
            if (exp_i_order[k]) chk("starve_cleared", dut.starve_cnt, 4'd0);
            bus.pmem_resp = 1'b1;
            #1;
            chk($sformatf("starve_resp%0d", k),
                exp_i_order[k] ? bus.icache_pmem_resp : bus.dcache_pmem_resp, 1'b1);
            tick();
            bus.pmem_resp = 1'b0;
            if (exp_i_order[k]) begin
                bus.icache_pmem_read = 1'b0;
            end else begin
                dcount++;
                if (dcount == 6) bus.dcache_pmem_read = 1'b0;
                else bus.dcache_pmem_address = 32'h00002000 + 32'(dcount) * 32'h20;
            end
            tick();
        end
        chk("starve_final", dut.starve_cnt, 4'd0);

        // Stray pmem_resp while idle.
        do_reset();
        bus.pmem_rdata = {32{8'hFF}};
        bus.pmem_resp  = 1'b1;
        #1;
        chk("idle_resp_ignored", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b00);
        tick();
        bus.pmem_resp = 1'b0;
        chk("idle_resp_state", dut.state, IDLE);

        // Reset two cycles into a dcache grant, followed by a late resp.
        do_reset();
        bus.dcache_pmem_read    = 1'b1;
        bus.dcache_pmem_address = 32'h00000500;
        tick();
        chk("rstmid_granted", bus.pmem_read, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.dcache_pmem_read = 1'b0;
        bus.pmem_resp        = 1'b1;
        #1;
        chk("rstmid_outputs", {bus.pmem_read, bus.pmem_write, bus.icache_pmem_resp, bus.dcache_pmem_resp}, 4'b0000);
        chk("rstmid_address", bus.pmem_address, 32'h0);
        tick();
        bus.pmem_resp = 1'b0;
        chk("rstmid_state", dut.state, IDLE);
        run_vec('{1'b1, 1'b0, 1'b0, 32'h00000600, 32'h0, 256'h0, {8{32'h600D600D}}, 2,
                  1'b1, 1'b0, 32'h00000600, 256'h0, 1'b1}, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Sits directly downstream of the datapath's icache and dcache.
- Both caches issue 256-bit cacheline misses and write-backs to a single cacheline adaptor / physical memory port; this block decides which cache owns that port.
- It serialises one line transaction at a time and routes the response back to the owner.
- dcache has priority, because its requester is older in the pipeline. A starvation guard keeps icache from being locked out by back-to-back dcache traffic.

Parameters:
- LINE_W, 256, cacheline width in bits.
- ADDR_W, 32, physical address width.
- STARVE_LIMIT, 4, consecutive dcache grants allowed while icache is pending before icache is forced to win; range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- icache_pmem_read  in  1  icache line-fill request; held until icache_pmem_resp.
- icache_pmem_address  in  ADDR_W  icache line address, bits [4:0] = 0.
- icache_pmem_rdata  out  LINE_W  fill data to icache.
- icache_pmem_resp  out  1  one-cycle completion pulse to icache.
- dcache_pmem_read  in  1  dcache line-fill request; held until dcache_pmem_resp.
- dcache_pmem_write  in  1  dcache write-back request; held until dcache_pmem_resp.
- dcache_pmem_address  in  ADDR_W  dcache line address.
- dcache_pmem_wdata  in  LINE_W  write-back data.
- dcache_pmem_rdata  out  LINE_W  fill data to dcache.
- dcache_pmem_resp  out  1  one-cycle completion pulse to dcache.
- pmem_read  out  1  read request to the adaptor.
- pmem_write  out  1  write request to the adaptor.
- pmem_address  out  ADDR_W  address to the adaptor.
- pmem_wdata  out  LINE_W  write data to the adaptor.
- pmem_rdata  in  LINE_W  read data from the adaptor.
- pmem_resp  in  1  adaptor completion pulse.

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, DONE. The state register, latched request, and starvation counter (4 bits) all reset to IDLE / 0 synchronously.
- Reset values: all pmem_* and *_resp outputs are 0. rdata outputs are don't-care and are driven as 0 under reset.

IDLE:
- A request is pending when the read or write line of a client is high.
- Arbitration:
  - Only dcache pending -> GRANT_D.
  - Only icache pending -> GRANT_I.
  - Both pending: GRANT_I if starve_cnt == STARVE_LIMIT, otherwise GRANT_D.
- On entering a grant state, latch the owner's address, wdata and op (read/write) into registers.
- No pmem_* output is asserted while in IDLE.

GRANT_x:
- pmem_read or pmem_write is driven from the latched op. pmem_address and pmem_wdata come from the latch.
- On pmem_resp:
  - Assert the owner's *_resp combinationally in the same cycle.
  - Pass pmem_rdata straight through to the owner's rdata.
  - Go to DONE.
- The non-owner's resp stays 0.
- No timeout.

DONE:
- One cycle in which no request is sampled, so the client can drop its held request; then return to IDLE.
- Minimum grant-to-grant spacing is therefore 3 cycles (grant, resp, DONE) plus the adaptor latency.

Starvation counter:
- On a GRANT_D entry while icache is pending: starve_cnt increments, saturating at STARVE_LIMIT.
- On a GRANT_I entry: starve_cnt resets to 0.
- On a GRANT_D entry with no icache pending: starve_cnt is unchanged.

Protocol edge cases:
- dcache read and write both high: illegal. Write takes precedence, and a simulation-only assertion fires.
- pmem_resp arriving in IDLE or DONE: ignored; no client resp is issued.
- Client request dropped mid-grant: illegal. The transaction completes on the latched values anyway.
- rst asserted during a grant: next cycle is IDLE with outputs low. A late pmem_resp is ignored. The adaptor is reset by the same rst.
- Latency from request to pmem_read is 1 cycle (registered grant).

Decomposition:
- Add arb_types package containing:
  - arb_state_t enum {IDLE, GRANT_I, GRANT_D, DONE}.
  - arb_op_t enum {OP_READ, OP_WRITE}.
  - LINE_W and ADDR_W defaults.
- Single module. Keep the next-state/arbitration logic in one always_comb, and the latch plus starve_cnt in one always_ff. No sub-module is warranted.

Test Plan:
- icache read only, addr 0x00000060, adaptor resp after 5 cycles with data 0xA5..A5:
  - pmem_read rises 1 cycle after the request, with pmem_address = 0x60.
  - icache_pmem_resp pulses for 1 cycle with rdata 0xA5..A5.
  - dcache_pmem_resp stays 0.
- icache read 0x100 and dcache write 0x200 (wdata 0x1234..) raised in the same cycle:
  - dcache is served first: pmem_write, address 0x200, correct wdata.
  - After the dcache resp and DONE, icache is granted with pmem_read at 0x100.
- dcache issues 6 back-to-back reads while icache holds a read, STARVE_LIMIT = 4:
  - Grant order is D, D, D, D, I, D, D.
  - starve_cnt returns to 0 after the icache grant.
- pmem_resp pulsed while in IDLE:
  - Neither client resp asserts.
  - State stays IDLE.
- rst asserted 2 cycles into a dcache grant, then pmem_resp arrives 1 cycle later:
  - Outputs are 0 the cycle after rst.
  - The late resp is ignored.
  - A new icache request is granted normally afterwards.
- dcache read and write both high:
  - The write is issued to the adaptor.
  - The assertion fires.
